// File: rtl/data_serializer_if.sv
// Handshake bundle for data_serializer: wide word in, narrow beats out.
// last_out exists only when DATA_SERIALIZER_LAST_EN is defined.
interface data_serializer_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8
);
  logic                 valid_in;
  logic [IN_WIDTH-1:0]  data_in;
  logic                 in_ready;
  logic                 valid_out;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 out_ready;
`ifdef DATA_SERIALIZER_LAST_EN
  logic                 last_out;
`endif

  modport master (
    output valid_in, data_in, out_ready,
    input  in_ready, valid_out, data_out
`ifdef DATA_SERIALIZER_LAST_EN
    , input last_out
`endif
  );

  modport slave (
    input  valid_in, data_in, out_ready,
    output in_ready, valid_out, data_out
`ifdef DATA_SERIALIZER_LAST_EN
    , output last_out
`endif
  );
endinterface

// File: rtl/data_serializer.sv
// Wide-to-narrow serializer: shift register + one-word pending buffer for full output rate.
// Optional last_out beat marker enabled by defining DATA_SERIALIZER_LAST_EN.
module data_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic clk_in,
  input  logic rst,
  data_serializer_if.slave bus
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
      $error("data_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t              state, state_nx;
  logic [IN_WIDTH-1:0] sr, pb, sr_shifted;
  logic [CW-1:0]       cnt;
  logic                accept, fire, cnt_last, lastfire;
  logic                load_in, load_pb, store_pb, shift;

  // in_ready depends on state only, so upstream never sees a combinational loop
  assign bus.in_ready  = (state != FULL);
  assign bus.valid_out = (state != EMPTY);
  assign accept        = bus.valid_in & bus.in_ready;
  assign fire          = bus.valid_out & bus.out_ready;
  assign cnt_last      = (cnt == CW'(RATIO - 1));
  assign lastfire      = fire & cnt_last;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_in  = 1'b0;
    load_pb  = 1'b0;
    store_pb = 1'b0;
    shift    = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        load_in  = 1'b1;
        state_nx = BUSY;
      end
      BUSY: begin
        if (lastfire) begin
          if (accept) load_in  = 1'b1;
          else        state_nx = EMPTY;
        end else begin
          shift = fire;
          if (accept) begin
            store_pb = 1'b1;
            state_nx = FULL;
          end
        end
      end
      FULL: begin
        if (lastfire) begin
          load_pb  = 1'b1;
          state_nx = BUSY;
        end else begin
          shift = fire;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // The beat on data_out is always the edge-aligned slice of sr
  always_comb begin
    if (MSB_FIRST != 0) sr_shifted = sr << OUT_WIDTH;
    else                sr_shifted = sr >> OUT_WIDTH;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      pb  <= '0;
      cnt <= '0;
    end else begin
      if (store_pb) pb <= bus.data_in;
      if (load_in) begin
        sr  <= bus.data_in;
        cnt <= '0;
      end else if (load_pb) begin
        sr  <= pb;
        cnt <= '0;
      end else if (shift) begin
        sr  <= sr_shifted;
        cnt <= cnt + 1'b1;
      end
    end
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign bus.data_out = sr[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
      assign bus.data_out = sr[OUT_WIDTH-1:0];
    end
  endgenerate

`ifdef DATA_SERIALIZER_LAST_EN
  assign bus.last_out = bus.valid_out & cnt_last;
`endif
endmodule
